// File: rtl/music_pkg.sv
// Shared types and constants for the rhythm-game note scheduler: FSM states,
// status codes, chart entry layout and lane geometry defaults.
package music_pkg;

  localparam int unsigned LANE_H_DEF   = 435;
  localparam int unsigned JUDGE_LO_DEF = 410;
  localparam int unsigned ENTRY_W      = 12;
  localparam int unsigned DELAY_W      = 8;
  localparam int unsigned LANES        = 4;
  localparam int unsigned MSG_W        = 3;
  localparam int unsigned SCORE_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_ROM = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  typedef enum logic [MSG_W-1:0] {
    MSG_BLANK = 3'd0,
    MSG_READY = 3'd1,
    MSG_HIT   = 3'd2,
    MSG_MISS  = 3'd3,
    MSG_END   = 3'd4
  } msg_t;

  // Chart ROM word: {delay[11:4] frames, lane_mask[3:0]}
  typedef struct packed {
    logic [DELAY_W-1:0] delay;
    logic [LANES-1:0]   lane_mask;
  } chart_entry_t;

endpackage

// File: rtl/note_lane.sv
// One note lane: scrolls the bitmap, spawns notes, clears the judge window on
// a key rising edge and flags notes that scroll off the bottom.
module note_lane
  import music_pkg::*;
#(
  parameter int unsigned LANE_H   = LANE_H_DEF,
  parameter int unsigned SPEED    = 4,
  parameter int unsigned NOTE_LEN = 16,
  parameter int unsigned JUDGE_LO = JUDGE_LO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              active,
  input  logic              tick,
  input  logic              spawn,
  input  logic              key,
  output logic [LANE_H-1:0] col,
  output logic              key_prev,
  output logic              hit_c,
  output logic              miss_c
);

  localparam logic [LANE_H-1:0] WIN_MASK  = {{(LANE_H-JUDGE_LO){1'b1}}, {JUDGE_LO{1'b0}}};
  localparam logic [LANE_H-1:0] NOTE_MASK = {{(LANE_H-NOTE_LEN){1'b0}}, {NOTE_LEN{1'b1}}};

  logic [LANE_H-1:0] cleared;
  logic [LANE_H-1:0] shifted;
  logic              key_rise;

  // Judge on pre-shift contents; the shift then operates on the cleared lane
  always_comb begin
    key_rise = key & ~key_prev;
    hit_c    = active & key_rise & (|(col & WIN_MASK));
    cleared  = hit_c ? (col & ~WIN_MASK) : col;
    shifted  = cleared << SPEED;
    miss_c   = active & tick & (|cleared[LANE_H-1 -: SPEED]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      key_prev <= 1'b0;
    end else begin
      key_prev <= key;
      if (clear)
        col <= '0;
      else if (active && tick)
        col <= shifted | (spawn ? NOTE_MASK : '0);
      else
        col <= cleared;
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Chart-driven note scheduler for a four-lane rhythm game.
// Define NOTE_SCHEDULER_SCORE_EN to add the saturating hit counter on score.
module note_scheduler
  import music_pkg::*;
#(
  parameter int unsigned LANE_H   = LANE_H_DEF,
  parameter int unsigned SPEED    = 4,
  parameter int unsigned NOTE_LEN = 16,
  parameter int unsigned JUDGE_LO = JUDGE_LO_DEF,
  parameter int unsigned CHART_AW = 10
) (
  input  logic                clk25MHZ,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                start,
  input  logic [LANES-1:0]    keys,
  output logic [CHART_AW-1:0] chart_addr,
  input  logic [ENTRY_W-1:0]  chart_data,
  output logic [LANE_H-1:0]   col1,
  output logic [LANE_H-1:0]   col2,
  output logic [LANE_H-1:0]   col3,
  output logic [LANE_H-1:0]   col4,
  output logic [LANES-1:0]    hits,
  output logic [MSG_W-1:0]    msg
`ifdef NOTE_SCHEDULER_SCORE_EN
  ,
  output logic [SCORE_W-1:0]  score
`endif
);

  state_t                state, state_n;
  logic [CHART_AW-1:0]   addr_n;
  logic [LANES-1:0]      entry_mask, entry_mask_n;
  logic [DELAY_W-1:0]    delay_cnt, delay_n;
  logic                  end_flag, end_n;
  logic [MSG_W-1:0]      msg_n;
  logic                  active, spawn, clear_lanes, lanes_zero;
  logic [LANES-1:0]      hit_c, miss_c;
  chart_entry_t          rom_entry;

  assign rom_entry  = chart_entry_t'(chart_data);
  assign active     = (state == ST_FETCH) || (state == ST_WAIT_ROM) || (state == ST_RUN);
  assign lanes_zero = ~|{col1, col2, col3, col4};

  always_ff @(posedge clk25MHZ) begin
    if (rst) begin
      state      <= ST_IDLE;
      chart_addr <= '0;
      entry_mask <= '0;
      delay_cnt  <= '0;
      end_flag   <= 1'b0;
      msg        <= MSG_READY;
    end else begin
      state      <= state_n;
      chart_addr <= addr_n;
      entry_mask <= entry_mask_n;
      delay_cnt  <= delay_n;
      end_flag   <= end_n;
      msg        <= msg_n;
    end
  end

  always_comb begin
    state_n      = state;
    addr_n       = chart_addr;
    entry_mask_n = entry_mask;
    delay_n      = delay_cnt;
    end_n        = end_flag;
    msg_n        = msg;
    spawn        = 1'b0;
    clear_lanes  = 1'b0;
    case (state)
      ST_IDLE: begin
        msg_n = MSG_READY;
        if (start) begin
          state_n = ST_FETCH;
          addr_n  = '0;
        end
      end
      ST_FETCH: state_n = ST_WAIT_ROM;
      ST_WAIT_ROM: begin
        entry_mask_n = rom_entry.lane_mask;
        if (chart_data == '0) end_n = 1'b1;
        else                  delay_n = rom_entry.delay;
        state_n = ST_RUN;
      end
      ST_RUN: begin
        if (end_flag && lanes_zero) begin
          state_n = ST_DONE;
          msg_n   = MSG_END;
        end else if (frame_tick) begin
          if (!end_flag && delay_cnt == '0) begin
            spawn   = 1'b1;
            addr_n  = chart_addr + CHART_AW'(1);
            state_n = ST_FETCH;
          end else if (delay_cnt != '0) begin
            delay_n = delay_cnt - DELAY_W'(1);
          end
        end
      end
      ST_DONE: begin
        msg_n = MSG_END;
        if (start) begin
          state_n     = ST_FETCH;
          addr_n      = '0;
          clear_lanes = 1'b1;
          end_n       = 1'b0;
          delay_n     = '0;
          msg_n       = MSG_READY;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A note lost off the bottom outranks a hit in the same cycle
    if (|miss_c)     msg_n = MSG_MISS;
    else if (|hit_c) msg_n = MSG_HIT;
  end

  note_lane #(.LANE_H(LANE_H), .SPEED(SPEED), .NOTE_LEN(NOTE_LEN), .JUDGE_LO(JUDGE_LO)) u_lane1 (
    .clk(clk25MHZ), .rst(rst), .clear(clear_lanes), .active(active), .tick(frame_tick),
    .spawn(spawn & entry_mask[0]), .key(keys[0]), .col(col1), .key_prev(hits[0]),
    .hit_c(hit_c[0]), .miss_c(miss_c[0]));

  note_lane #(.LANE_H(LANE_H), .SPEED(SPEED), .NOTE_LEN(NOTE_LEN), .JUDGE_LO(JUDGE_LO)) u_lane2 (
    .clk(clk25MHZ), .rst(rst), .clear(clear_lanes), .active(active), .tick(frame_tick),
    .spawn(spawn & entry_mask[1]), .key(keys[1]), .col(col2), .key_prev(hits[1]),
    .hit_c(hit_c[1]), .miss_c(miss_c[1]));

  note_lane #(.LANE_H(LANE_H), .SPEED(SPEED), .NOTE_LEN(NOTE_LEN), .JUDGE_LO(JUDGE_LO)) u_lane3 (
    .clk(clk25MHZ), .rst(rst), .clear(clear_lanes), .active(active), .tick(frame_tick),
    .spawn(spawn & entry_mask[2]), .key(keys[2]), .col(col3), .key_prev(hits[2]),
    .hit_c(hit_c[2]), .miss_c(miss_c[2]));

  note_lane #(.LANE_H(LANE_H), .SPEED(SPEED), .NOTE_LEN(NOTE_LEN), .JUDGE_LO(JUDGE_LO)) u_lane4 (
    .clk(clk25MHZ), .rst(rst), .clear(clear_lanes), .active(active), .tick(frame_tick),
    .spawn(spawn & entry_mask[3]), .key(keys[3]), .col(col4), .key_prev(hits[3]),
    .hit_c(hit_c[3]), .miss_c(miss_c[3]));

`ifdef NOTE_SCHEDULER_SCORE_EN
  logic [SCORE_W-1:0] score_n;

  // One point per cycle with any hit; cleared whenever play (re)starts
  always_comb begin
    score_n = score;
    if (start && (state == ST_IDLE || state == ST_DONE))
      score_n = '0;
    else if ((|hit_c) && score != {SCORE_W{1'b1}})
      score_n = score + SCORE_W'(1);
  end

  always_ff @(posedge clk25MHZ) begin
    if (rst) score <= '0;
    else     score <= score_n;
  end
`endif

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: notes are tracked as row segments per lane and the
// chart player as "entry live N cycles after request", checked every cycle.
module tb_note_scheduler;

  localparam int LH = 435;
  localparam int SP = 4;
  localparam int NL = 16;
  localparam int JL = 410;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, frame_tick, start;
  logic [3:0]    keys;
  logic [AW-1:0] chart_addr;
  logic [11:0]   chart_data = '0;
  logic [LH-1:0] col1, col2, col3, col4;
  logic [3:0]    hits;
  logic [2:0]    msg;
`ifdef NOTE_SCHEDULER_SCORE_EN
  logic [15:0]   score;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  note_scheduler #(.LANE_H(LH), .SPEED(SP), .NOTE_LEN(NL), .JUDGE_LO(JL), .CHART_AW(AW)) dut (
    .clk25MHZ(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .keys(keys),
    .chart_addr(chart_addr), .chart_data(chart_data),
    .col1(col1), .col2(col2), .col3(col3), .col4(col4), .hits(hits), .msg(msg)
`ifdef NOTE_SCHEDULER_SCORE_EN
    , .score(score)
`endif
  );

  // Chart ROM with one cycle of read latency
  logic [11:0] rom [1024];
  always @(posedge clk) chart_data <= rom[chart_addr];

  // ---------------- behavioural model ----------------
  typedef struct { int lane; int lo; int hi; } seg_t;
  seg_t       segs[$];
  seg_t       m_tmp[$];
  seg_t       m_s;
  bit         m_play, m_done, m_elig, m_ended, m_any_hit, m_any_miss, m_inwin;
  int         m_wait, m_idx, m_cnt, m_msg, m_score;
  logic [3:0] m_hits, m_mask, m_rise;
  logic [11:0] m_entry;

  function automatic logic [LH-1:0] lane_bits(input int n);
    logic [LH-1:0] b;
    b = '0;
    foreach (segs[i])
      if (segs[i].lane == n)
        for (int r = segs[i].lo; r <= segs[i].hi; r++) b[r] = 1'b1;
    return b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      segs.delete();
      m_play = 0; m_done = 0; m_elig = 0; m_ended = 0;
      m_wait = 0; m_idx = 0; m_cnt = 0; m_msg = 1; m_score = 0;
      m_hits = '0; m_mask = '0;
    end else begin
      m_rise = keys & ~m_hits;
      m_any_hit = 0;
      m_any_miss = 0;
      if (!m_play && !m_done) begin
        m_msg = 1;
        if (start) begin
          m_play = 1; m_idx = 0; m_wait = 2; m_elig = 0; m_ended = 0; m_score = 0;
        end
      end else if (m_done) begin
        m_msg = 4;
        if (start) begin
          segs.delete();
          m_done = 0; m_play = 1; m_idx = 0; m_wait = 2; m_elig = 0; m_ended = 0;
          m_score = 0; m_msg = 1;
        end
      end else if (m_elig && m_ended && segs.size() == 0) begin
        m_play = 0; m_done = 1; m_msg = 4;
      end else begin
        for (int n = 0; n < 4; n++) begin
          if (m_rise[n]) begin
            m_inwin = 0;
            foreach (segs[i]) if (segs[i].lane == n && segs[i].hi >= JL) m_inwin = 1;
            if (m_inwin) begin
              m_any_hit = 1;
              m_tmp.delete();
              foreach (segs[i]) begin
                m_s = segs[i];
                if (m_s.lane == n && m_s.hi >= JL) begin
                  if (m_s.lo < JL) begin
                    m_s.hi = JL - 1;
                    m_tmp.push_back(m_s);
                  end
                end else begin
                  m_tmp.push_back(m_s);
                end
              end
              segs = m_tmp;
            end
          end
        end
        if (frame_tick) begin
          m_tmp.delete();
          foreach (segs[i]) begin
            m_s = segs[i];
            m_s.lo += SP;
            m_s.hi += SP;
            if (m_s.hi > LH - 1) begin
              m_any_miss = 1;
              m_s.hi = LH - 1;
            end
            if (m_s.lo <= LH - 1) m_tmp.push_back(m_s);
          end
          segs = m_tmp;
          if (m_elig && !m_ended && m_cnt == 0) begin
            for (int n = 0; n < 4; n++)
              if (m_mask[n]) begin
                m_s.lane = n; m_s.lo = 0; m_s.hi = NL - 1;
                segs.push_back(m_s);
              end
            m_idx++;
            m_elig = 0;
            m_wait = 3;
          end else if (m_elig && m_cnt != 0) begin
            m_cnt--;
          end
        end
        if (m_any_miss)     m_msg = 3;
        else if (m_any_hit) m_msg = 2;
        if (m_any_hit && m_score < 65535) m_score++;
        if (!m_elig) begin
          m_wait--;
          if (m_wait == 0) begin
            m_entry = rom[m_idx % 1024];
            m_elig = 1;
            if (m_entry == 12'h000) m_ended = 1;
            else begin
              m_cnt  = int'(m_entry[11:4]);
              m_mask = m_entry[3:0];
            end
          end
        end
      end
      m_hits = keys;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [LH-1:0] act, input logic [LH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("col1", col1, lane_bits(0));
      check("col2", col2, lane_bits(1));
      check("col3", col3, lane_bits(2));
      check("col4", col4, lane_bits(3));
      check("hits", LH'(hits), LH'(m_hits));
      check("msg", LH'(msg), LH'(m_msg));
      check("chart_addr", LH'(chart_addr), LH'(m_idx % 1024));
`ifdef NOTE_SCHEDULER_SCORE_EN
      check("score", LH'(score), LH'(m_score));
`endif
    end
  end

  task automatic step(input bit tick, input logic [3:0] k, input bit st);
    frame_tick = tick;
    keys = k;
    start = st;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] k);
    rst = 1'b1;
    step(0, k, 0);
    step(0, k, 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 12'h000;
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; keys = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_msg", LH'(msg), LH'(1));
    check("reset_col1", col1, '0);
    check("reset_addr", LH'(chart_addr), '0);
    check("reset_hits", LH'(hits), '0);
    chk_en = 1'b1;
    rst = 1'b0;

    // A: first spawn timing, empty-window presses, tick+hit together, end/restart
    rom[0] = 12'h011;
    rom[1] = 12'h000;
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, 0);
    step(1, 4'b0000, 0);
    step(0, 4'b0000, 0);
    step(1, 4'b0000, 0);
    check("a_spawn_col1", col1, LH'(16'hFFFF));
    check("a_spawn_addr", LH'(chart_addr), LH'(1));
    step(0, 4'b0011, 0);
    step(0, 4'b0000, 0);
    for (int i = 0; i < 104; i++) begin
      step(1, 4'b0000, 0);
      step(0, 4'b0000, 0);
    end
    step(1, 4'b0001, 0);
    check("a_hit_col1", col1, '0);
    check("a_hit_msg", LH'(msg), LH'(2));
`ifdef NOTE_SCHEDULER_SCORE_EN
    check("a_hit_score", LH'(score), LH'(1));
`endif
    step(0, 4'b0001, 0);
    check("a_end_msg", LH'(msg), LH'(4));
    step(0, 4'b0000, 0);
    step(0, 4'b0000, 1);
    check("a_restart_addr", LH'(chart_addr), '0);
    check("a_restart_col1", col1, '0);
`ifdef NOTE_SCHEDULER_SCORE_EN
    check("a_restart_score", LH'(score), '0);
`endif
    step(0, 4'b0000, 0);

    // B: unplayed col2 note; first row falls off on the 106th tick incl. spawn
    do_reset(4'b0000);
    rom[0] = 12'h002;
    rom[1] = 12'h000;
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, 0);
    step(1, 4'b0000, 0);
    for (int t = 2; t <= 105; t++) begin
      step(0, 4'b0000, 0);
      step(1, 4'b0000, 0);
    end
    check("b_premiss_msg", LH'(msg), LH'(1));
    step(0, 4'b0000, 0);
    step(1, 4'b0000, 0);
    check("b_miss_msg", LH'(msg), LH'(3));
    for (int t = 107; t <= 110; t++) begin
      step(0, 4'b0000, 0);
      step(1, 4'b0000, 0);
    end
    check("b_drained_col2", col2, '0);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 0);
    check("b_end_msg", LH'(msg), LH'(4));

    // C: col3 partially in the window, hit clears rows 410..419; reset mid-run
    do_reset(4'b0000);
    rom[0] = 12'h004;
    rom[1] = 12'h000;
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, 0);
    step(1, 4'b0000, 0);
    step(0, 4'b0100, 0);
    step(0, 4'b0000, 0);
    for (int i = 0; i < 101; i++) begin
      step(0, 4'b0000, 0);
      step(1, 4'b0000, 0);
    end
    step(0, 4'b0100, 0);
    check("c_hit_col3", col3, LH'(6'h3F) << 404);
    check("c_hit_msg", LH'(msg), LH'(2));
`ifdef NOTE_SCHEDULER_SCORE_EN
    check("c_hit_score", LH'(score), LH'(1));
`endif
    step(0, 4'b0000, 0);
    step(1, 4'b0000, 0);
    step(1, 4'b0000, 0);
    rst = 1'b1;
    step(0, 4'b1111, 0);
    check("c_rst_col3", col3, '0);
    check("c_rst_addr", LH'(chart_addr), '0);
    check("c_rst_msg", LH'(msg), LH'(1));
    check("c_rst_hits", LH'(hits), '0);
`ifdef NOTE_SCHEDULER_SCORE_EN
    check("c_rst_score", LH'(score), '0);
`endif
    step(0, 4'b0000, 0);
    rst = 1'b0;

    // D: dense chart with a tick every cycle, chart address wraps past 1023
    for (int i = 0; i < 1024; i++) rom[i] = 12'h001;
    step(0, 4'b0000, 1);
    for (int i = 0; i < 4200; i++) step(1, (i % 7 == 0) ? 4'b0001 : 4'b0000, 0);
    do_reset(4'b0000);
    step(0, 4'b0000, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
